// File: rtl/ccip_if_pkg.sv
// CCI-P c1 (write) channel types used by the DMA write engine.
package ccip_if_pkg;

  localparam int unsigned CCIP_CLADDR_WIDTH = 42;
  localparam int unsigned CCIP_CLDATA_WIDTH = 512;
  localparam int unsigned CCIP_MDATA_WIDTH  = 16;

  typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
  typedef logic [CCIP_CLDATA_WIDTH-1:0] t_ccip_clData;
  typedef logic [CCIP_MDATA_WIDTH-1:0]  t_ccip_mdata;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  // Write/fence request header
  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  // Write/fence response header
  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

endpackage

// File: rtl/dma_write_engine.sv
// Streams a contiguous run of cache lines to host memory over CCI-P c1,
// counts write completions, optionally fences, then pulses done.
module dma_write_engine
  import ccip_if_pkg::*;
#(
  parameter bit         USE_FENCE = 1'b1,
  parameter logic [7:0] MDATA_TAG = 8'h00
) (
  input  logic           clk,
  input  logic           reset_n,
  input  t_ccip_clAddr   dst_addr,
  input  logic [31:0]    dst_ncl,
  input  logic           start,
  input  logic [511:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  t_if_ccip_c1_Rx c1rx,
  input  logic           c1TxAlmFull,
  output t_if_ccip_c1_Tx c1tx,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int unsigned NCL_W   = 32;
  localparam int unsigned ADDR_W  = CCIP_CLADDR_WIDTH;
  localparam int unsigned MDATA_W = CCIP_MDATA_WIDTH;
  localparam int unsigned TAG_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_RSP,
    S_FENCE,
    S_WAIT_FENCE,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  t_ccip_clAddr     addr_q, addr_d;
  logic [NCL_W-1:0] ncl_q, ncl_d;
  logic [NCL_W-1:0] req_idx_q, req_idx_d;
  logic [NCL_W-1:0] rsp_idx_q, rsp_idx_d;
  t_if_ccip_c1_Tx   c1tx_q, c1tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             rsp_match;
  logic             wr_rsp;
  logic             fence_rsp;
  logic             count_en;
  logic             accept;
  logic             unused_rx;

  // Response decode: only our own tag is of interest
  always_comb begin
    rsp_match = c1rx.rspValid && (c1rx.hdr.mdata[TAG_W-1:0] == MDATA_TAG);
    wr_rsp    = rsp_match && (c1rx.hdr.resp_type == eRSP_WRLINE);
    fence_rsp = rsp_match && (c1rx.hdr.resp_type == eRSP_WRFENCE);
  end

  assign unused_rx = ^{c1rx.hdr.vc_used, c1rx.hdr.rsvd1, c1rx.hdr.hit_miss,
                       c1rx.hdr.format, c1rx.hdr.rsvd0, c1rx.hdr.cl_num,
                       c1rx.hdr.mdata[MDATA_W-1:TAG_W]};

  // Payload handshake is combinational so a beat is taken in the cycle it is offered
  assign in_ready = (state_q == S_RUN) && !c1TxAlmFull && (req_idx_q != ncl_q);
  assign accept   = in_valid && in_ready;

  // Next-state, request build and completion counting
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ncl_d     = ncl_q;
    req_idx_d = req_idx_q;
    rsp_idx_d = rsp_idx_q;
    err_d     = err_q;
    c1tx_d    = '0;
    count_en  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = dst_addr;
          ncl_d     = dst_ncl;
          req_idx_d = '0;
          rsp_idx_d = '0;
          err_d     = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        count_en = 1'b1;
        if (accept) begin
          c1tx_d.valid        = 1'b1;
          c1tx_d.hdr.req_type = eREQ_WRLINE_I;
          c1tx_d.hdr.vc_sel   = eVC_VA;
          c1tx_d.hdr.cl_len   = eCL_LEN_1;
          c1tx_d.hdr.sop      = 1'b1;
          c1tx_d.hdr.address  = addr_q + ADDR_W'(req_idx_q);
          c1tx_d.hdr.mdata    = MDATA_W'(MDATA_TAG);
          c1tx_d.data         = in_data;
          req_idx_d           = req_idx_q + NCL_W'(1);
        end
        if (req_idx_q == ncl_q) begin
          state_d = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        count_en = 1'b1;
        if (rsp_idx_q == ncl_q) begin
          state_d = USE_FENCE ? S_FENCE : S_FINISH;
        end
      end
      S_FENCE: begin
        count_en = 1'b1;
        if (!c1TxAlmFull) begin
          c1tx_d.valid        = 1'b1;
          c1tx_d.hdr.req_type = eREQ_WRFENCE;
          c1tx_d.hdr.vc_sel   = eVC_VA;
          c1tx_d.hdr.mdata    = MDATA_W'(MDATA_TAG);
          state_d             = S_WAIT_FENCE;
        end
      end
      S_WAIT_FENCE: begin
        count_en = 1'b1;
        if (fence_rsp) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A completion beyond the expected count is an error, the counter saturates
    if (count_en && wr_rsp) begin
      if (rsp_idx_q == ncl_q) begin
        err_d = 1'b1;
      end else begin
        rsp_idx_d = rsp_idx_q + NCL_W'(1);
      end
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      ncl_q     <= '0;
      req_idx_q <= '0;
      rsp_idx_q <= '0;
      c1tx_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ncl_q     <= ncl_d;
      req_idx_q <= req_idx_d;
      rsp_idx_q <= rsp_idx_d;
      c1tx_q    <= c1tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign c1tx = c1tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_dma_write_engine.sv
// Randomized bench for dma_write_engine against a line/response counting model.
module tb_dma_write_engine;
  import ccip_if_pkg::*;

  localparam logic [7:0] TAG      = 8'h00;
  localparam int         M_RAND   = 0;
  localparam int         M_ALMWIN = 1;
  localparam int         M_BADMD  = 2;
  localparam int         M_EXTRA  = 3;
  localparam int         M_STREAM = 4;
  localparam int         M_ABORT  = 5;

  logic           clk = 1'b0;
  logic           reset_n;
  t_ccip_clAddr   dst_addr;
  logic [31:0]    dst_ncl;
  logic           start;
  logic [511:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  t_if_ccip_c1_Rx c1rx;
  logic           c1TxAlmFull;
  t_if_ccip_c1_Tx c1tx;
  logic           busy;
  logic           done;
  logic           err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;

  // pending responses: due cycle, kind (0 = write line, 1 = fence), tag
  int          rq_due[$];
  int          rq_kind[$];
  logic [7:0]  rq_md[$];

  always #5 clk = ~clk;

  dma_write_engine #(
    .USE_FENCE (1'b1),
    .MDATA_TAG (TAG)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dst_addr    (dst_addr),
    .dst_ncl     (dst_ncl),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .c1rx        (c1rx),
    .c1TxAlmFull (c1TxAlmFull),
    .c1tx        (c1tx),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic t_ccip_clAddr rand_addr();
    return {10'($urandom), 32'($urandom)};
  endfunction

  task automatic push_rsp(input int due, input int kind, input logic [7:0] md);
    rq_due.push_back(due);
    rq_kind.push_back(kind);
    rq_md.push_back(md);
  endtask

  // Drive at most one due response; the fence answer waits until no write answers remain
  task automatic drive_rsp(output int kind, output logic [7:0] md);
    int pick;
    bit wr_pending;
    pick       = -1;
    wr_pending = 1'b0;
    kind       = -1;
    md         = 8'h00;
    foreach (rq_kind[i]) if (rq_kind[i] == 0) wr_pending = 1'b1;
    foreach (rq_due[i]) begin
      if (pick < 0 && rq_due[i] <= cyc && (rq_kind[i] == 0 || !wr_pending)) pick = i;
    end
    c1rx = '0;
    if (pick >= 0) begin
      kind = rq_kind[pick];
      md   = rq_md[pick];
      c1rx.rspValid      = 1'b1;
      c1rx.hdr.resp_type = (kind == 0) ? eRSP_WRLINE : eRSP_WRFENCE;
      c1rx.hdr.mdata     = {8'($urandom), md};
      c1rx.hdr.cl_num    = 2'($urandom);
      rq_due.delete(pick);
      rq_kind.delete(pick);
      rq_md.delete(pick);
    end
  endtask

  task automatic run_job(input int ncl, input int mode, input t_ccip_clAddr base);
    int           acc, good, jc, kind, dly;
    bit           exp_wr, exp_ready, fence_seen, fence_rsp_prev, prev_alm, got_done, injected;
    t_ccip_clAddr exp_addr;
    logic [511:0] exp_data;
    logic [7:0]   md;
    acc = 0; good = 0; jc = 0; kind = -1;
    exp_wr = 0; exp_ready = 0; fence_seen = 0; fence_rsp_prev = 0;
    prev_alm = 0; got_done = 0; injected = 0;
    exp_addr = '0; exp_data = '0; md = 8'h00;
    rq_due.delete(); rq_kind.delete(); rq_md.delete();

    @(negedge clk); cyc++;
    dst_addr = base; dst_ncl = 32'(ncl); start = 1'b1;
    in_valid = 1'b0; c1TxAlmFull = 1'b0; c1rx = '0;

    while (!got_done && jc < 400) begin
      @(negedge clk); cyc++; jc++;
      // registered outputs produced by the previous edge
      check("busy", busy, 1'b1);
      if (jc == 1) check("err_clr", err, 1'b0);
      check("done", done, fence_rsp_prev);
      if (fence_rsp_prev) begin
        check("err", err, good > ncl);
        got_done = 1'b1;
      end
      if (exp_wr) begin
        check("wr_valid", c1tx.valid, 1'b1);
        check("wr_type", c1tx.hdr.req_type, eREQ_WRLINE_I);
        check("wr_addr", c1tx.hdr.address, exp_addr);
        check("wr_data", c1tx.data, exp_data);
        check("wr_fields", {c1tx.hdr.vc_sel, c1tx.hdr.cl_len, c1tx.hdr.sop, c1tx.hdr.mdata[7:0]},
              {eVC_VA, eCL_LEN_1, 1'b1, TAG});
        dly = (mode == M_STREAM) ? 3 : (mode == M_ABORT) ? 30 : $urandom_range(1, 8);
        push_rsp(cyc + dly, 0, TAG);
        if (!injected && mode == M_BADMD) push_rsp(cyc + 1, 0, 8'h55);
        if (!injected && mode == M_EXTRA) push_rsp(cyc + $urandom_range(1, 8), 0, TAG);
        injected = 1'b1;
      end else if (c1tx.valid) begin
        check("fence_hdr", {c1tx.hdr.req_type, c1tx.hdr.vc_sel, c1tx.hdr.mdata[7:0]},
              {eREQ_WRFENCE, eVC_VA, TAG});
        check("fence_when", {fence_seen, good >= ncl, prev_alm}, 3'b010);
        if (!fence_seen) push_rsp(cyc + $urandom_range(1, 4), 1, TAG);
        fence_seen = 1'b1;
      end

      if (mode == M_ABORT && acc >= 2) begin
        in_valid = 1'b0; c1TxAlmFull = 1'b0; c1rx = '0; start = 1'b0;
        return;
      end

      // stimulus for this cycle
      start = (mode == M_RAND && jc == 1);
      dst_addr = ~base;
      dst_ncl  = 32'(ncl + 5);
      case (mode)
        M_ALMWIN: c1TxAlmFull = (jc >= 3 && jc <= 6);
        M_STREAM, M_ABORT: c1TxAlmFull = 1'b0;
        default:  c1TxAlmFull = ($urandom_range(0, 3) == 0);
      endcase
      case (mode)
        M_ALMWIN, M_STREAM: in_valid = 1'b1;
        M_ABORT:  in_valid = (acc < 2);
        default:  in_valid = ($urandom_range(0, 3) != 0);
      endcase
      for (int k = 0; k < 16; k++) in_data[k*32 +: 32] = $urandom;
      drive_rsp(kind, md);
      prev_alm = c1TxAlmFull;

      #1;
      exp_ready = (acc < ncl) && !c1TxAlmFull;
      check("in_ready", in_ready, exp_ready);
      exp_wr = in_valid && exp_ready;
      if (exp_wr) begin
        exp_addr = base + t_ccip_clAddr'(acc);
        exp_data = in_data;
        acc++;
      end
      fence_rsp_prev = (kind == 1 && md == TAG);
      if (kind == 0 && md == TAG) good++;
    end

    check("job_done", got_done, 1'b1);
    @(negedge clk); cyc++;
    in_valid = 1'b0; c1TxAlmFull = 1'b0; c1rx = '0; start = 1'b0;
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_ready", in_ready, 1'b0);
    check("idle_err", err, good > ncl);
    rq_due.delete(); rq_kind.delete(); rq_md.delete();
  endtask

  initial begin
    int         kind;
    logic [7:0] md;
    int         n, m;
    reset_n = 1'b0; start = 1'b0; dst_addr = '0; dst_ncl = '0;
    in_data = '0; in_valid = 1'b0; c1rx = '0; c1TxAlmFull = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, done, err, in_ready, c1tx.valid}, 5'b0);
    reset_n = 1'b1;
    @(negedge clk); cyc++;

    run_job(4, M_STREAM, rand_addr());
    run_job(8, M_ALMWIN, rand_addr());
    run_job(0, M_RAND, rand_addr());
    run_job(3, M_BADMD, rand_addr());
    run_job(2, M_EXTRA, rand_addr());
    run_job(6, M_RAND, {42{1'b1}} - t_ccip_clAddr'(2));

    // abort with two writes outstanding, then late answers land in idle
    run_job(5, M_ABORT, rand_addr());
    reset_n = 1'b0;
    #1;
    check("abort_outputs", {busy, done, err, in_ready, c1tx.valid}, 5'b0);
    @(negedge clk); cyc++;
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk); cyc++;
      check("post_abort", {busy, done, err, c1tx.valid}, 4'b0);
      drive_rsp(kind, md);
    end
    @(negedge clk); cyc++;
    c1rx = '0;
    check("post_abort_idle", {busy, done, err, in_ready}, 4'b0);
    run_job(1, M_RAND, rand_addr());

    repeat (12) begin
      n = $urandom_range(0, 10);
      m = (n == 0) ? M_RAND : $urandom_range(0, 3);
      run_job(n, m, rand_addr());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_write_engine.md
Name: dma_write_engine

Overview:
- Streams a contiguous run of 512-bit cache lines from an on-chip producer into host memory over the CCI-P c1 (write) channel.
- It is the write-side counterpart to the SSSP DMA read engine. It issues one single-line write per accepted input beat, tracks write completions, and optionally issues a write fence.
- It pulses done once every line (and the fence, if enabled) is acknowledged.

Parameters:
- USE_FENCE, 1, when 1 a WrFence is sent after all line writes complete and done waits for its response.
- MDATA_TAG, 8'h00, value placed in hdr.mdata[7:0] of every request; responses are counted only when mdata[7:0] matches this value.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- dst_addr  input  t_ccip_clAddr  base cache-line address, latched on start
- dst_ncl  input  32  number of lines to write, latched on start
- start  input  1  one-cycle start pulse, ignored unless IDLE
- in_data  input  512  line payload
- in_valid  input  1  payload valid
- in_ready  output  1  engine accepts payload this cycle
- c1rx  input  t_if_ccip_c1_Rx  write/fence responses
- c1TxAlmFull  input  1  c1 almost-full backpressure
- c1tx  output  t_if_ccip_c1_Tx  write/fence requests, registered
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  sticky: response received with rsp_idx already equal to ncl; cleared on start

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, c1tx.valid=0, in_ready=0, done=0, err=0, busy=0, req_idx=rsp_idx=0.
- States: IDLE, RUN, WAIT_RSP, FENCE, WAIT_FENCE, FINISH.
- IDLE, on start:
  - Latch dst_addr to addr_q and dst_ncl to ncl_q.
  - Clear req_idx, rsp_idx and err.
  - Go to RUN.
- RUN:
  - in_ready is combinational: (state==RUN) && !c1TxAlmFull && (req_idx != ncl_q).
  - On in_valid && in_ready, the next cycle drives c1tx.valid=1 with:
    - hdr.req_type=eREQ_WRLINE_I, vc_sel=eVC_VA, cl_len=eCL_LEN_1, sop=1
    - address=addr_q+req_idx (wraps modulo clAddr width), mdata=MDATA_TAG, data=in_data
  - On the same accept, req_idx increments. Request latency is 1 cycle.
  - c1tx.valid defaults to 0 every cycle. The engine never issues a request while c1TxAlmFull is high in the accepting cycle.
  - When req_idx==ncl_q, go to WAIT_RSP.
- WAIT_RSP: when rsp_idx==ncl_q, go to FENCE if USE_FENCE else FINISH.
- FENCE:
  - Waits until !c1TxAlmFull.
  - Then issues one request next cycle: req_type=eREQ_WRFENCE, vc_sel=eVC_VA, mdata=MDATA_TAG.
  - Then goes to WAIT_FENCE.
- WAIT_FENCE: on c1rx.rspValid with resp_type==eRSP_WRFENCE and mdata match, go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Response counting:
  - Applies in RUN, WAIT_RSP, FENCE and WAIT_FENCE.
  - Counted: c1rx.rspValid with resp_type==eRSP_WRLINE and mdata match increments rsp_idx by 1.
  - Not counted: responses in IDLE/FINISH and responses with mismatched mdata.
  - If rsp_idx==ncl_q when a counted response arrives, rsp_idx holds and err sets.
- Completions may arrive out of order. Only the count matters.
- A response and a request in the same cycle are independent; both counters update.
- dst_ncl==0: RUN immediately goes to WAIT_RSP, then FENCE/FINISH. in_ready is never asserted.
- start while busy is ignored. Latched values are unaffected.
- Reset mid-operation aborts immediately. Responses arriving afterwards land in IDLE and are ignored.
- busy = (state!=IDLE).

Test Plan:
- ncl=4, in_valid always 1, no almfull, responses 3 cycles after each request -> 4 writes at addr_q+0..3 on consecutive cycles. With USE_FENCE=1, one fence follows the 4th response and done pulses 1 cycle after the fence response.
- ncl=8, c1TxAlmFull high for cycles 3-6 -> in_ready low for those cycles, no c1tx.valid the cycle after each, all 8 addresses still issued exactly once in order.
- ncl=0, start -> no WRLINE issued, in_ready never high. With USE_FENCE=0, done pulses 2 cycles after start.
- ncl=3, one response with mdata=8'h55 (MDATA_TAG=0) injected -> ignored, rsp_idx reaches 3 only from the 3 real responses, err stays 0.
- ncl=2, 3 matching responses -> err=1 after the third, done still pulses once.
- reset_n dropped for 1 cycle while 2 of 5 writes are outstanding -> all outputs 0 asynchronously, late responses ignored. A new start with ncl=1 completes normally.
